// File: rtl/instr_fetch_pkg.sv
// Shared constants for the fetch stage and its neighbours: FSM encodings,
// reset/increment constants, ALU op/source codes and a branch-offset helper.
package instr_fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Default PC after reset and the sequential word increment
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // ALU operation codes used by the control unit
  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_SLT = 4'd4;

  // ALU second-operand source codes
  localparam logic [1:0] ALU_SRC_REG  = 2'd0;
  localparam logic [1:0] ALU_SRC_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_UIMM = 2'd2;

  // Sign-extend a 16-bit word offset and convert it to a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats pc+4.
module next_pc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  output logic [31:0] npc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;

  assign w_pc_plus4  = pc + PC_INCR;
  assign w_br_target = w_pc_plus4 + branch_offset(imm16);

  // Priority select of the redirect target
  always_comb begin
    npc = w_pc_plus4;
    if (is_jump) begin
      npc = {w_pc_plus4[31:28], addr26, 2'b00};
    end else if (is_branch && branch_taken) begin
      npc = w_br_target;
    end else begin
      npc = w_pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word at pc, holds it for decode until
// the downstream completes it, then advances pc (sequential or redirected).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  output logic [31:0] retired
);

  // pc is kept word aligned even if RESET_PC is not
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic         r_imem_req;
  logic         w_imem_req_nxt;
  logic [31:0]  r_instruction;
  logic [31:0]  w_instruction_nxt;
  logic         r_instr_valid;
  logic         w_instr_valid_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_retired;
  logic [31:0]  w_retired_nxt;
  logic [31:0]  w_npc;

  next_pc u_next_pc (
    .pc           (r_pc),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .addr26       (addr26),
    .npc          (w_npc)
  );

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_imem_req    <= 1'b0;
      r_instruction <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
      r_pc          <= RESET_PC_ALIGNED;
      r_retired     <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_imem_req    <= w_imem_req_nxt;
      r_instruction <= w_instruction_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_pc          <= w_pc_nxt;
      r_retired     <= w_retired_nxt;
    end
  end

  // Next-state and next-register values; acks outside WAIT and ready
  // without a valid instruction fall through to the hold defaults
  always_comb begin
    w_state_nxt       = r_state;
    w_imem_req_nxt    = r_imem_req;
    w_instruction_nxt = r_instruction;
    w_instr_valid_nxt = r_instr_valid;
    w_pc_nxt          = r_pc;
    w_retired_nxt     = r_retired;
    case (r_state)
      ST_FETCH: begin
        w_imem_req_nxt = 1'b1;
        w_state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ack) begin
          w_imem_req_nxt    = 1'b0;
          w_instruction_nxt = imem_rdata;
          w_instr_valid_nxt = 1'b1;
          w_state_nxt       = ST_HOLD;
        end else begin
          w_imem_req_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (instr_ready && r_instr_valid) begin
          w_instr_valid_nxt = 1'b0;
          w_pc_nxt          = {w_npc[31:2], 2'b00};
          w_retired_nxt     = r_retired + 32'd1;
          w_state_nxt       = ST_FETCH;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_imem_req_nxt    = 1'b0;
        w_instr_valid_nxt = 1'b0;
        w_state_nxt       = ST_FETCH;
      end
    endcase
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instruction = r_instruction;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign retired     = r_retired;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned read address (equals pc).
REQ-006 imem_ack  input  1  read data valid this cycle.
REQ-007 imem_rdata  input  32  instruction word from memory.
REQ-008 instruction  output  32  held instruction word, to the control decoder.
REQ-009 pc  output  32  address of the held instruction.
REQ-010 instr_valid  output  1  instruction/pc valid for decode.
REQ-011 instr_ready  input  1  downstream has completed the held instruction this cycle.
REQ-012 is_jump, is_branch  input  1 each  decoder redirect flags for the held instruction.
REQ-013 branch_taken  input  1  branch condition result from the ALU.
REQ-014 imm16  input  16  branch offset from the decoder.
REQ-015 addr26  input  26  jump target from the decoder.
REQ-016 retired  output  32  count of completed instructions.

Function
REQ-017 The FSM SHALL have three states: FETCH, WAIT, HOLD.
REQ-018 FETCH SHALL assert imem_req with imem_addr=pc for one cycle, then go to WAIT.
REQ-019 In WAIT, imem_req SHALL stay high until imem_ack=1; on ack: capture imem_rdata into instruction, set instr_valid=1, go to HOLD.
REQ-020 imem_ack in FETCH or HOLD SHALL be ignored.
REQ-021 In HOLD, instruction and pc SHALL be stable while instr_ready=0.
REQ-022 In HOLD with instr_ready=1:
- clear instr_valid
- update pc per REQ-023
- increment retired (mod 2^32)
- go to FETCH.
REQ-023 Next pc, priority order:
- is_jump=1: {pc_plus4[31:28], addr26, 2'b00}
- is_branch=1 and branch_taken=1: pc_plus4 + (sign-extended imm16 << 2)
- otherwise: pc_plus4
- pc_plus4 = pc+4, 32-bit wrap-around.
REQ-024 is_jump, is_branch, branch_taken, imm16 and addr26 SHALL be sampled only in the HOLD cycle with instr_ready=1.
REQ-025 instr_ready while instr_valid=0 SHALL have no effect.
REQ-026 pc[1:0] SHALL always be 2'b00.
REQ-027 Minimum cycles per instruction SHALL be 3 (FETCH, WAIT with ack, HOLD with ready); each memory wait cycle adds one.
REQ-028 pc 32'hFFFF_FFFC with no redirect SHALL wrap to 32'h0000_0000.

Reset
REQ-029 On reset, all of the following SHALL be forced immediately, regardless of clk:
- state=FETCH
- pc=RESET_PC
- instruction=0
- instr_valid=0
- imem_req=0
- retired=0
REQ-030 Reset asserted mid-WAIT SHALL abandon the request; an ack in the first cycle after reset SHALL be ignored.
REQ-031 The first imem_req SHALL assert in the first clk edge after reset deasserts.

Structure
REQ-032 The FSM state encodings, the RESET_PC default and the word-increment constant 4 SHALL live in the shared constants include, beside the ALU op and ALU source codes.
REQ-033 Next-pc computation SHALL be a combinational sub-module, next_pc, with inputs pc, is_jump, is_branch, branch_taken, imm16, addr26 and output npc.
REQ-034 The block SHALL connect directly to the control unit's instruction input and its is_jump/is_branch/imm16/addr26 outputs.

Verification
REQ-035 Sequential, no redirect:
- Stimulus: reset, memory returns 32'h2010FEFE at 0, ack after 0 wait cycles, ready=1 in HOLD.
- Response: pc sequence 0, 4, 8; instr_valid pulses every 3 cycles; retired=3 after third completion.
REQ-036 Jump:
- Stimulus: held pc=32'h0040_0010, is_jump=1, addr26=26'h0100000, ready=1.
- Response: next imem_addr=32'h0040_0000.
REQ-037 Taken backward branch:
- Stimulus: pc=32'h0000_0020, is_branch=1, branch_taken=1, imm16=16'hFFFD.
- Response: next pc=32'h0000_0018.
- Same stimulus with branch_taken=0: next pc=32'h0000_0024.
REQ-038 Wait states and stall:
- Ack delayed 4 cycles: imem_req high throughout.
- ready held low 5 cycles: instruction/pc unchanged; retired unchanged until ready.
REQ-039 Reset in WAIT:
- Stimulus: assert reset with ack arriving the next cycle; RESET_PC=32'h0000_1000.
- Response: instr_valid stays 0; the first post-reset fetch is from 32'h0000_1000.
REQ-040 Spurious signals:
- ack in HOLD: instruction unchanged.
- ready in WAIT: pc and retired unchanged.
